// File: rtl/flow_ctrl_if.sv
// Pipeline flow-control bundle: hazard inputs from the ID/EX/MEM stages and
// the stall/flush/redirect controls returned to the pipeline registers and PC.
interface flow_ctrl_if;
  // Hazard sources
  logic        ex_jump_flag_i;
  logic [31:0] ex_jump_pc_i;
  logic        idex_mtype_i;
  logic        idex_mem_rw_i;
  logic [4:0]  idex_reg_waddr_i;
  logic [4:0]  id_rs1_raddr_i;
  logic [4:0]  id_rs2_raddr_i;
  logic        id_rs1_re_i;
  logic        id_rs2_re_i;
  logic        mem_req_i;
  logic        mem_ready_i;

  // Pipeline controls
  logic        fc_stall_pc_o;
  logic        fc_stall_ifid_o;
  logic        fc_stall_idex_o;
  logic        fc_stall_exmem_o;
  logic        fc_flush_ifid_o;
  logic        fc_flush_idex_o;
  logic        fc_flush_exmem_o;
  logic        fc_jump_flag_o;
  logic [31:0] fc_jump_pc_o;
  logic        fc_bus_err_o;
  logic [31:0] fc_stall_cnt_o;

  // Pipeline side: produces hazard sources, consumes controls
  modport master (
    output ex_jump_flag_i, ex_jump_pc_i, idex_mtype_i, idex_mem_rw_i,
           idex_reg_waddr_i, id_rs1_raddr_i, id_rs2_raddr_i, id_rs1_re_i,
           id_rs2_re_i, mem_req_i, mem_ready_i,
    input  fc_stall_pc_o, fc_stall_ifid_o, fc_stall_idex_o, fc_stall_exmem_o,
           fc_flush_ifid_o, fc_flush_idex_o, fc_flush_exmem_o, fc_jump_flag_o,
           fc_jump_pc_o, fc_bus_err_o, fc_stall_cnt_o
  );

  // Flow-control unit side
  modport slave (
    input  ex_jump_flag_i, ex_jump_pc_i, idex_mtype_i, idex_mem_rw_i,
           idex_reg_waddr_i, id_rs1_raddr_i, id_rs2_raddr_i, id_rs1_re_i,
           id_rs2_re_i, mem_req_i, mem_ready_i,
    output fc_stall_pc_o, fc_stall_ifid_o, fc_stall_idex_o, fc_stall_exmem_o,
           fc_flush_ifid_o, fc_flush_idex_o, fc_flush_exmem_o, fc_jump_flag_o,
           fc_jump_pc_o, fc_bus_err_o, fc_stall_cnt_o
  );
endinterface

// File: rtl/flow_ctrl.sv
// Pipeline flow-control unit for the five-stage core. Resolves load-use
// hazards, EX-resolved jumps and data-bus waits (with timeout), and keeps a
// saturating count of PC-stall cycles.
module flow_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16  // legal range 1..255
) (
  input  logic        clk,
  input  logic        rst_n,
  flow_ctrl_if.slave  fc
);

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t      state_q;
  logic [7:0]  wait_cnt_q;
  logic        bus_err_q;
  logic [31:0] stall_cnt_q;

  logic        mem_stall;
  logic        timeout;
  logic        load_use;
  logic        stall_pc, stall_ifid, stall_idex, stall_exmem;
  logic        flush_ifid, flush_idex, flush_exmem;
  logic        jump_flag;
  logic [31:0] jump_pc;

  // Hazard detection and prioritised stall/flush/redirect decode
  always_comb begin
    // NOTE: every signal gets a default before the priority chain so no path
    // leaves one unassigned, which would otherwise infer a latch.
    mem_stall   = 1'b0;
    timeout     = 1'b0;
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_exmem = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    jump_flag   = 1'b0;
    jump_pc     = 32'h0;

    if (state_q == IDLE) begin
      mem_stall = fc.mem_req_i & ~fc.mem_ready_i;
    end else begin
      mem_stall = ~fc.mem_ready_i & (wait_cnt_q != TIMEOUT_CNT);
      timeout   = ~fc.mem_ready_i & (wait_cnt_q == TIMEOUT_CNT);
    end

    load_use = fc.idex_mtype_i & ~fc.idex_mem_rw_i &
               (fc.idex_reg_waddr_i != 5'd0) &
               ((fc.id_rs1_re_i & (fc.id_rs1_raddr_i == fc.idex_reg_waddr_i)) |
                (fc.id_rs2_re_i & (fc.id_rs2_raddr_i == fc.idex_reg_waddr_i)));

    if (mem_stall) begin
      // Freeze everything; a jump waiting in EX is replayed once the bus frees
      stall_pc    = 1'b1;
      stall_ifid  = 1'b1;
      stall_idex  = 1'b1;
      stall_exmem = 1'b1;
    end else if (timeout) begin
      // Abort the hung access by dropping it from EX/MEM
      flush_exmem = 1'b1;
    end else if (fc.ex_jump_flag_i) begin
      // Redirect and squash the two younger instructions
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      jump_flag  = 1'b1;
      jump_pc    = fc.ex_jump_pc_i;
    end else if (load_use) begin
      // Hold IF/ID and insert a bubble; ID/EX must not also stall, since it
      // gives stall priority over flush and the bubble would be lost
      stall_pc   = 1'b1;
      stall_ifid = 1'b1;
      flush_idex = 1'b1;
    end
  end

  // Bus-wait FSM, timeout error pulse and saturating stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 8'd0;
      bus_err_q   <= 1'b0;
      stall_cnt_q <= 32'h0;
    end else begin
      bus_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fc.mem_req_i && !fc.mem_ready_i) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (fc.mem_ready_i) begin
            state_q    <= IDLE;
            wait_cnt_q <= 8'd0;
          end else if (wait_cnt_q == TIMEOUT_CNT) begin
            state_q    <= IDLE;
            wait_cnt_q <= 8'd0;
            bus_err_q  <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q    <= IDLE;
          wait_cnt_q <= 8'd0;
        end
      endcase

      if (stall_pc && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  // Drive the interface outputs
  assign fc.fc_stall_pc_o    = stall_pc;
  assign fc.fc_stall_ifid_o  = stall_ifid;
  assign fc.fc_stall_idex_o  = stall_idex;
  assign fc.fc_stall_exmem_o = stall_exmem;
  assign fc.fc_flush_ifid_o  = flush_ifid;
  assign fc.fc_flush_idex_o  = flush_idex;
  assign fc.fc_flush_exmem_o = flush_exmem;
  assign fc.fc_jump_flag_o   = jump_flag;
  assign fc.fc_jump_pc_o     = jump_pc;
  assign fc.fc_bus_err_o     = bus_err_q;
  assign fc.fc_stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_flow_ctrl.sv
// Self-checking bench for flow_ctrl (MEM_TIMEOUT = 4). Expected outputs are
// pushed to a scoreboard queue as each cycle's stimulus is driven and popped
// for comparison once the outputs have settled in that cycle.
module tb_flow_ctrl;

  localparam int unsigned TO = 4;

  // Flag order: stall_pc, stall_ifid, stall_idex, stall_exmem,
  //             flush_ifid, flush_idex, flush_exmem, jump_flag, bus_err
  localparam logic [8:0] F_NONE  = 9'b0000_000_0_0;
  localparam logic [8:0] F_MEM   = 9'b1111_000_0_0;
  localparam logic [8:0] F_LU    = 9'b1100_010_0_0;
  localparam logic [8:0] F_JMP   = 9'b0000_110_1_0;
  localparam logic [8:0] F_TO    = 9'b0000_001_0_0;
  localparam logic [8:0] F_ERR   = 9'b0000_000_0_1;

  typedef struct packed {
    logic [8:0]  flags;
    logic [31:0] jump_pc;
    logic [31:0] stall_cnt;
  } out_t;

  typedef struct packed {
    logic        mreq, mrdy, jmp;
    logic [31:0] jpc;
    logic        mtype, rw;
    logic [4:0]  waddr, rs1;
    logic        re1;
    logic [4:0]  rs2;
    logic        re2;
  } in_t;

  logic clk;
  logic rst_n;
  flow_ctrl_if fc();

  flow_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fc    (fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  out_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_cnt  = 32'h0;

  function automatic in_t mk_in(logic mreq, logic mrdy, logic jmp, logic [31:0] jpc);
    in_t v = '0;
    v.mreq = mreq; v.mrdy = mrdy; v.jmp = jmp; v.jpc = jpc;
    return v;
  endfunction

  function automatic in_t mk_lu(logic mtype, logic rw, logic [4:0] waddr,
                                logic [4:0] rs1, logic re1, logic [4:0] rs2, logic re2);
    in_t v = '0;
    v.mtype = mtype; v.rw = rw; v.waddr = waddr;
    v.rs1 = rs1; v.re1 = re1; v.rs2 = rs2; v.re2 = re2;
    return v;
  endfunction

  // Expected outputs for the current cycle; advances the bench's own count
  // of expected PC-stall cycles (saturating) for the following cycles.
  function automatic out_t mk_exp(logic [8:0] flags, logic [31:0] pc);
    out_t e;
    e.flags     = flags;
    e.jump_pc   = pc;
    e.stall_cnt = exp_cnt;
    if (flags[8] && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
    return e;
  endfunction

  task automatic drive(in_t v);
    fc.mem_req_i        = v.mreq;
    fc.mem_ready_i      = v.mrdy;
    fc.ex_jump_flag_i   = v.jmp;
    fc.ex_jump_pc_i     = v.jpc;
    fc.idex_mtype_i     = v.mtype;
    fc.idex_mem_rw_i    = v.rw;
    fc.idex_reg_waddr_i = v.waddr;
    fc.id_rs1_raddr_i   = v.rs1;
    fc.id_rs1_re_i      = v.re1;
    fc.id_rs2_raddr_i   = v.rs2;
    fc.id_rs2_re_i      = v.re2;
  endtask

  function automatic out_t obs();
    out_t o;
    o.flags = {fc.fc_stall_pc_o, fc.fc_stall_ifid_o, fc.fc_stall_idex_o,
               fc.fc_stall_exmem_o, fc.fc_flush_ifid_o, fc.fc_flush_idex_o,
               fc.fc_flush_exmem_o, fc.fc_jump_flag_o, fc.fc_bus_err_o};
    o.jump_pc   = fc.fc_jump_pc_o;
    o.stall_cnt = fc.fc_stall_cnt_o;
    return o;
  endfunction

  task automatic test_reset();
    out_t got, exp;
    drive('0);
    rst_n = 1'b0;
    exp_cnt = 32'h0;
    #3;
    sb_q.push_back(mk_exp(F_NONE, 32'h0));
    got = obs();
    exp = sb_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL reset got %h want %h", got, exp);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    in_t si[$];
    logic [8:0] ef[$];
    out_t got, exp;
    si.push_back(mk_lu(1, 0, 5'd5, 5'd5, 1, 5'd0, 0)); ef.push_back(F_LU);   // rs1 hit
    si.push_back('0);                                  ef.push_back(F_NONE); // bubble
    si.push_back(mk_lu(1, 0, 5'd5, 5'd0, 1, 5'd5, 1)); ef.push_back(F_LU);   // rs2 hit
    si.push_back(mk_lu(1, 0, 5'd0, 5'd0, 1, 5'd0, 1)); ef.push_back(F_NONE); // x0 dest
    si.push_back(mk_lu(1, 1, 5'd5, 5'd5, 1, 5'd0, 0)); ef.push_back(F_NONE); // store
    si.push_back(mk_lu(1, 0, 5'd5, 5'd5, 0, 5'd5, 0)); ef.push_back(F_NONE); // not read
    si.push_back(mk_lu(0, 0, 5'd5, 5'd5, 1, 5'd0, 0)); ef.push_back(F_NONE); // not mem
    si.push_back(mk_lu(1, 0, 5'd7, 5'd5, 1, 5'd6, 1)); ef.push_back(F_NONE); // no match
    foreach (si[i]) begin
      @(negedge clk);
      drive(si[i]);
      sb_q.push_back(mk_exp(ef[i], 32'h0));
      #2;
      got = obs();
      exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL load_use[%0d] got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_branch();
    in_t si[$];
    logic [8:0] ef[$];
    logic [31:0] ep[$];
    in_t v;
    out_t got, exp;
    si.push_back(mk_in(0, 0, 1, 32'h0000_0100)); ef.push_back(F_JMP);  ep.push_back(32'h100);
    v = mk_lu(1, 0, 5'd5, 5'd5, 1, 5'd0, 0);
    v.jmp = 1'b1; v.jpc = 32'h1234_5678;
    si.push_back(v);                             ef.push_back(F_JMP);  ep.push_back(32'h1234_5678);
    si.push_back(mk_in(0, 0, 0, 32'hDEAD_BEEF)); ef.push_back(F_NONE); ep.push_back(32'h0);
    foreach (si[i]) begin
      @(negedge clk);
      drive(si[i]);
      sb_q.push_back(mk_exp(ef[i], ep[i]));
      #2;
      got = obs();
      exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL branch[%0d] got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_bus_wait();
    in_t si[$];
    logic [8:0] ef[$];
    out_t got, exp;
    si.push_back(mk_in(1, 1, 0, 0)); ef.push_back(F_NONE); // ready at once
    si.push_back(mk_in(1, 0, 0, 0)); ef.push_back(F_MEM);
    si.push_back(mk_in(1, 0, 0, 0)); ef.push_back(F_MEM);
    si.push_back(mk_in(1, 0, 0, 0)); ef.push_back(F_MEM);
    si.push_back(mk_in(1, 1, 0, 0)); ef.push_back(F_NONE); // ready on 4th cycle
    si.push_back(mk_in(0, 0, 0, 0)); ef.push_back(F_NONE);
    si.push_back(mk_in(1, 1, 0, 0)); ef.push_back(F_NONE); // back in IDLE
    foreach (si[i]) begin
      @(negedge clk);
      drive(si[i]);
      sb_q.push_back(mk_exp(ef[i], 32'h0));
      #2;
      got = obs();
      exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL bus_wait[%0d] got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_timeout();
    in_t si[$];
    logic [8:0] ef[$];
    out_t got, exp;
    // Single timeout, request dropped afterwards
    for (int c = 0; c < int'(TO); c++) begin
      si.push_back(mk_in(1, 0, 0, 0)); ef.push_back(F_MEM);
    end
    si.push_back(mk_in(1, 0, 0, 0)); ef.push_back(F_TO);
    si.push_back(mk_in(0, 0, 0, 0)); ef.push_back(F_ERR);
    si.push_back(mk_in(0, 0, 0, 0)); ef.push_back(F_NONE);
    // Request held through the timeout: a fresh wait starts from count 1
    for (int c = 0; c < int'(TO); c++) begin
      si.push_back(mk_in(1, 0, 0, 0)); ef.push_back(F_MEM);
    end
    si.push_back(mk_in(1, 0, 0, 0)); ef.push_back(F_TO);
    si.push_back(mk_in(1, 0, 0, 0)); ef.push_back(F_MEM | F_ERR);
    for (int c = 1; c < int'(TO); c++) begin
      si.push_back(mk_in(1, 0, 0, 0)); ef.push_back(F_MEM);
    end
    si.push_back(mk_in(1, 0, 0, 0)); ef.push_back(F_TO);
    si.push_back(mk_in(0, 0, 0, 0)); ef.push_back(F_ERR);
    si.push_back(mk_in(0, 0, 0, 0)); ef.push_back(F_NONE);
    foreach (si[i]) begin
      @(negedge clk);
      drive(si[i]);
      sb_q.push_back(mk_exp(ef[i], 32'h0));
      #2;
      got = obs();
      exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL timeout[%0d] got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_jump_during_wait();
    in_t si[$];
    logic [8:0] ef[$];
    logic [31:0] ep[$];
    out_t got, exp;
    si.push_back(mk_in(1, 0, 1, 32'h0000_0200)); ef.push_back(F_MEM);  ep.push_back(32'h0);
    si.push_back(mk_in(1, 0, 1, 32'h0000_0200)); ef.push_back(F_MEM);  ep.push_back(32'h0);
    si.push_back(mk_in(1, 1, 1, 32'h0000_0200)); ef.push_back(F_JMP);  ep.push_back(32'h200);
    si.push_back(mk_in(0, 0, 0, 32'h0));         ef.push_back(F_NONE); ep.push_back(32'h0);
    foreach (si[i]) begin
      @(negedge clk);
      drive(si[i]);
      sb_q.push_back(mk_exp(ef[i], ep[i]));
      #2;
      got = obs();
      exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL jump_wait[%0d] got %h want %h", i, got, exp);
      end
    end
  endtask

  // Reset asserted mid-wait (cycle 2) and in the timeout cycle (cycle TO)
  task automatic test_reset_mid_wait();
    int at[2];
    out_t got, exp;
    at[0] = 2;
    at[1] = int'(TO);
    foreach (at[k]) begin
      for (int c = 0; c < at[k]; c++) begin
        @(negedge clk);
        drive(mk_in(1, 0, 0, 0));
        sb_q.push_back(mk_exp(F_MEM, 32'h0));
        #2;
        got = obs();
        exp = sb_q.pop_front();
        n_checks++;
        if (got !== exp) begin
          n_errors++;
          $display("FAIL rst_wait%0d pre[%0d] got %h want %h", k, c, got, exp);
        end
      end
      @(negedge clk);
      drive('0);
      rst_n = 1'b0;
      exp_cnt = 32'h0;
      #2;
      sb_q.push_back(mk_exp(F_NONE, 32'h0));
      got = obs();
      exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL rst_wait%0d in_reset got %h want %h", k, got, exp);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        drive(c == 3 ? mk_in(1, 1, 0, 0) : in_t'('0));
        sb_q.push_back(mk_exp(F_NONE, 32'h0));
        #2;
        got = obs();
        exp = sb_q.pop_front();
        n_checks++;
        if (got !== exp) begin
          n_errors++;
          $display("FAIL rst_wait%0d post[%0d] got %h want %h", k, c, got, exp);
        end
      end
    end
  endtask

  task automatic test_saturation();
    out_t got, exp;
    @(negedge clk);
    drive('0);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    exp_cnt = 32'hFFFF_FFFE;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(c < 4 ? mk_lu(1, 0, 5'd9, 5'd9, 1, 5'd0, 0) : in_t'('0));
      sb_q.push_back(mk_exp(c < 4 ? F_LU : F_NONE, 32'h0));
      #2;
      got = obs();
      exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL saturate[%0d] got %h want %h", c, got, exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive('0);
    test_reset();
    test_load_use();
    test_branch();
    test_bus_wait();
    test_timeout();
    test_jump_during_wait();
    test_reset_mid_wait();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
